// File: rtl/ntsc_vram_pkg.sv
// Frame-buffer layout shared by the NTSC writer and the XGA reader:
// address field positions, active-area defaults and packed-word byte order.
package ntsc_vram_pkg;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int V_ACTIVE_DEF = 768;

    localparam int COL_W     = 8;
    localparam int LINE_W    = 9;
    localparam int FIELD_BIT = COL_W;
    localparam int ADDR_W    = 1 + LINE_W + 1 + COL_W;

    // Leftmost display pixel of a word sits in the most significant byte
    localparam int PIX0_LSB = 24;
    localparam int PIX1_LSB = 16;
    localparam int PIX2_LSB = 8;
    localparam int PIX3_LSB = 0;

    typedef logic [31:0]       vram_word_t;
    typedef logic [ADDR_W-1:0] vram_addr_t;

    function automatic vram_addr_t vram_word_addr(input logic [9:0] vcount,
                                                  input logic [10:0] hcount);
        return {1'b0, vcount[LINE_W:1], vcount[0], hcount[COL_W+1:2]};
    endfunction

    function automatic logic [7:0] word_byte(input vram_word_t w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[PIX0_LSB +: 8];
            2'd1:    b = w[PIX1_LSB +: 8];
            2'd2:    b = w[PIX2_LSB +: 8];
            default: b = w[PIX3_LSB +: 8];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// N-stage shift register with a per-bit reset value; used for syncs/blank,
// the load tag and the column-phase delay.
module sync_delay #(
    parameter int             W       = 1,
    parameter int             N       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [N];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[N-1];

endmodule

// File: rtl/vram_bw_reader.sv
// Display-side reader of the NTSC frame buffer: one ZBT word read per four
// XGA pixels, unpacked to 8-bit luminance with optional black/white threshold.
module vram_bw_reader
    import ntsc_vram_pkg::*;
#(
    parameter int READ_LAT = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic        mode,
    input  logic [7:0]  threshold,
    output logic [18:0] vram_addr,
    output logic        vram_rd,
    input  logic [35:0] vram_read_data,
    output logic [7:0]  pixel,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out
);

    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

    logic       issue;
    vram_addr_t addr_d, addr_q;
    logic       rd_q;
    logic       load_tag;
    vram_word_t word_q;
    logic       blank_sel;
    logic [1:0] col_sel;
    logic [7:0] pix_byte;
    logic [7:0] pixel_d, pixel_q;
    logic       unused_hi;

    assign unused_hi = ^vram_read_data[35:32];

    // Request stage: address/strobe registered one cycle after hcount
    assign issue = (hcount < H_LIM) && (vcount < V_LIM) && (hcount[1:0] == 2'b00);

    always_comb begin
        addr_d = addr_q;
        if (issue) addr_d = vram_word_addr(vcount, hcount);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            rd_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            rd_q   <= issue;
        end
    end

    assign vram_addr = addr_q;
    assign vram_rd   = rd_q;

    // Tag reaches the end of the line in the cycle the ZBT word is on the bus
    sync_delay #(.W(1), .N(READ_LAT + 1), .RST_VAL(1'b0)) u_load_tag (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (issue),
        .q_o    (load_tag)
    );

    sync_delay #(.W(3), .N(READ_LAT + 2), .RST_VAL(3'b100)) u_sel_delay (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    ({blank_in, hcount[1:0]}),
        .q_o    ({blank_sel, col_sel})
    );

    sync_delay #(.W(3), .N(READ_LAT + 3), .RST_VAL(3'b111)) u_sync_delay (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    ({hsync_in, vsync_in, blank_in}),
        .q_o    ({hsync_out, vsync_out, blank_out})
    );

    // Capture and unpack stage
    assign pix_byte = word_byte(word_q, col_sel);

    always_comb begin
        pixel_d = pix_byte;
        if (mode) pixel_d = (pix_byte >= threshold) ? 8'hFF : 8'h00;
        if (blank_sel) pixel_d = 8'h00;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q  <= '0;
            pixel_q <= '0;
        end else begin
            if (load_tag) word_q <= vram_read_data[31:0];
            pixel_q <= pixel_d;
        end
    end

    assign pixel = pixel_q;

endmodule

// File: tb/tb_vram_bw_reader.sv
// Scoreboard bench for vram_bw_reader: a stimulus process predicts strobes and
// pixels from a frame-buffer model, a monitor pops and compares every cycle.
module tb_vram_bw_reader;

    localparam int RL = 2;
    localparam int L  = RL + 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        hsync_in = 1'b1, vsync_in = 1'b1, blank_in = 1'b1;
    logic        mode = 1'b0;
    logic [7:0]  threshold = '0;
    logic [18:0] vram_addr;
    logic        vram_rd;
    logic [35:0] vram_read_data = '0;
    logic [7:0]  pixel;
    logic        hsync_out, vsync_out, blank_out;

    always #5 clk = ~clk;

    vram_bw_reader #(.READ_LAT(RL), .H_ACTIVE(1024), .V_ACTIVE(768)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hcount         (hcount),
        .vcount         (vcount),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .blank_in       (blank_in),
        .mode           (mode),
        .threshold      (threshold),
        .vram_addr      (vram_addr),
        .vram_rd        (vram_rd),
        .vram_read_data (vram_read_data),
        .pixel          (pixel),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .blank_out      (blank_out)
    );

    typedef struct { int cyc; logic rd; logic [18:0] addr; } exp_rd_t;
    typedef struct { int cyc; logic [7:0] pix; logic hs; logic vs; logic bl; } exp_pix_t;
    typedef struct { logic [7:0] pb; logic hs; logic vs; logic bl; } rec_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_cnt = 0;
    logic [31:0] mem [int];
    exp_rd_t  rq[$];
    exp_pix_t pq[$];
    rec_t     pipe[$];
    logic [18:0] ahist[$];
    logic [18:0] last_addr = '0;
    logic [31:0] cur_word = '0;
    bit mode_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_rd(input logic [18:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return (32'(a) * 32'h9E3779B1) ^ 32'hC3A55A3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // ZBT model: data for the address presented RL cycles earlier
    always @(negedge clk) begin
        ahist.push_back(vram_addr);
        if (ahist.size() > RL) vram_read_data = {4'($urandom), mem_rd(ahist.pop_front())};
    end

    // Monitor
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_rd", 32'(vram_rd), 0);
            chk("rst_addr", 32'(vram_addr), 0);
            chk("rst_pixel", 32'(pixel), 0);
            chk("rst_syncs", {29'd0, hsync_out, vsync_out, blank_out}, 32'd7);
        end else begin
            if (vram_rd) rd_cnt++;
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                chk("rd_missed", 32'(rq[0].cyc), 32'(cyc));
                void'(rq.pop_front());
            end
            while (pq.size() > 0 && pq[0].cyc < cyc) begin
                chk("pix_missed", 32'(pq[0].cyc), 32'(cyc));
                void'(pq.pop_front());
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                exp_rd_t e;
                e = rq.pop_front();
                chk("vram_rd", 32'(vram_rd), 32'(e.rd));
                chk("vram_addr", 32'(vram_addr), 32'(e.addr));
            end
            if (pq.size() > 0 && pq[0].cyc == cyc) begin
                exp_pix_t p;
                p = pq.pop_front();
                chk("pixel", 32'(pixel), 32'(p.pix));
                chk("syncs", {29'd0, hsync_out, vsync_out, blank_out}, {29'd0, p.hs, p.vs, p.bl});
            end
        end
    end

    // One display cycle of stimulus plus the reference prediction for it
    task automatic step(input int h, input int v, input bit rel);
        bit   issue;
        int   ph;
        rec_t r;
        logic [7:0] px;
        @(posedge clk); #1;
        if (rel) begin
            reset_n = 1'b1;
            rq.push_back(exp_rd_t'{cyc, 1'b0, 19'd0});
            pq.push_back(exp_pix_t'{cyc, 8'd0, 1'b1, 1'b1, 1'b1});
            pipe.delete();
            for (int i = 0; i < L - 1; i++) pipe.push_back(rec_t'{8'd0, 1'b1, 1'b1, 1'b1});
            last_addr = '0;
            cur_word  = '0;
        end
        hcount   = 11'(h);
        vcount   = 10'(v);
        blank_in = (h >= 1024) || (v >= 768);
        hsync_in = !(h >= 1048 && h < 1184);
        vsync_in = !(v >= 771 && v < 777);
        if (mode_rand && $urandom_range(0, 49) == 0) mode = ~mode;

        issue = (h < 1024) && (v < 768) && (h % 4 == 0);
        if (issue) begin
            last_addr = 19'(((v / 2) << 9) | ((v % 2) << 8) | ((h / 4) % 256));
            cur_word  = mem_rd(last_addr);
        end
        rq.push_back(exp_rd_t'{cyc + 1, issue, last_addr});

        ph = 3 - (h % 4);
        r.pb = 8'((cur_word >> (8 * ph)) & 32'hFF);
        r.hs = hsync_in;
        r.vs = vsync_in;
        r.bl = blank_in;
        pipe.push_back(r);
        if (pipe.size() >= L) begin
            r = pipe.pop_front();
            if (r.bl)      px = 8'h00;
            else if (mode) px = (r.pb >= threshold) ? 8'hFF : 8'h00;
            else           px = r.pb;
            pq.push_back(exp_pix_t'{cyc + 1, px, r.hs, r.vs, r.bl});
        end
    endtask

    task automatic line(input int v);
        int c0;
        c0 = rd_cnt;
        for (int h = 0; h < 1344; h++) step(h, v, 1'b0);
        @(negedge clk); #1;
        chk("rd_per_line", 32'(rd_cnt - c0), (v < 768) ? 32'd256 : 32'd0);
    endtask

    initial begin
        mem[0]   = 32'h11223344;
        mem[512] = 32'h7F80FF00;

        #2 reset_n = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            hcount    = 11'($urandom_range(0, 1343));
            vcount    = 10'($urandom_range(0, 805));
            hsync_in  = 1'($urandom);
            vsync_in  = 1'($urandom);
            blank_in  = 1'($urandom);
            mode      = 1'($urandom);
            threshold = 8'($urandom);
        end

        mode = 1'b0;
        threshold = 8'h00;
        step(517, 4, 1'b1);
        for (int h = 518; h < 1344; h++) step(h, 4, 1'b0);

        line(0);
        mode = 1'b1; threshold = 8'h80;
        line(2);
        mode = 1'b0;
        line(161);
        mode_rand = 1'b1;
        for (int v = 300; v < 303; v++) begin
            threshold = 8'($urandom);
            line(v);
        end
        line(767);
        mode_rand = 1'b0;
        line(768);
        line(805);
        for (int h = 0; h < 12; h++) step(h, 0, 1'b0);
        repeat (L + 2) step(1100, 0, 1'b0);

        @(negedge clk); #1;
        chk("rd_queue_drained", 32'(rq.size()), 32'd1);
        chk("pix_queue_drained", 32'(pq.size()), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
